uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART engine with one transmitter and one receiver.
- Replaces the fixed 8-bit core. Adds configurable data width, parity mode, stop-bit count and baud divisor.
- Adds false-start rejection and break handling.
- Sits between the byte-level host logic and the serial pins. Port names match the existing UART interface signals, so the current UVM agents reconnect unchanged when DATA_BITS=8.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be ≥4 and even.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_start  in  1  request to send tx_data; sampled only when the TX FSM is in IDLE
- tx_data  in  DATA_BITS  word to transmit; latched on accepted tx_start
- tx_serial  out  1  serial TX line, idle high
- tx_active  out  1  high from the first start-bit cycle through the last stop-bit cycle
- tx_done  out  1  one-cycle pulse at frame end
- rx_serial  in  1  asynchronous serial RX line
- rx_data  out  DATA_BITS  last received word
- rx_done  out  1  one-cycle pulse when rx_data and the error flags update
- parity_error  out  1  parity mismatch on the last frame; always 0 when PARITY_MODE=0
- frame_error  out  1  low stop bit on the last frame

Behaviour:
- Reset, asynchronous, effective immediately, including mid-frame:
  - tx_serial=1; tx_active, tx_done, rx_done, parity_error, frame_error = 0; rx_data = 0.
  - Both FSMs go to IDLE. No done pulse is issued for an aborted frame.
- Frame length: N = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS bits. Each bit is exactly CLKS_PER_BIT cycles.
- Parity bit: even = XOR of the data bits; odd = inverted XOR.
- TX FSM: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - Accepted tx_start at cycle t → tx_serial=0 and tx_active=1 from cycle t+1.
  - A baud counter runs 0..CLKS_PER_BIT-1. The bit index increments when the counter wraps.
  - The last stop-bit cycle is t+N·CLKS_PER_BIT. In the following cycle the FSM is in IDLE, tx_done=1 and tx_active=0.
  - tx_start while not in IDLE is ignored.
  - tx_start in the tx_done cycle is accepted (back-to-back frames). In that case tx_active stays low for exactly that one cycle.
- RX input: rx_serial passes through a 2-flop synchroniser. All RX references below use the synchronised line.
- RX FSM: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - IDLE arms only after the line has been seen high at least once since reset or since the last frame ended.
  - An armed IDLE on a low line → START. The counter runs to CLKS_PER_BIT/2-1, then the line is re-sampled.
  - If the line is high at that sample: false start → IDLE, no pulse, no flag change.
  - After a valid start, each following bit is sampled at mid-bit, every CLKS_PER_BIT cycles.
  - When STOP_BITS=2, both stop bits are sampled. Any stop sample at 0 sets frame_error.
  - At the final stop sample, in the same cycle: rx_data is written (even on error), parity_error and frame_error are updated, and rx_done=1. The FSM then enters IDLE.
  - The error flags hold until the next rx_done.
- rx_done latency: from the rx_serial falling edge, 2 + CLKS_PER_BIT/2 + (N−1)·CLKS_PER_BIT cycles, ±1.
- Break (line low for the whole frame): one rx_done with rx_data=0 and frame_error=1. The receiver then stays in IDLE, disarmed, until the line returns high.
- TX and RX are fully independent. Simultaneous activity on both is legal.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each RX bit, including the start re-check, is sampled at mid-1, mid and mid+1. The value used is the 2-of-3 majority. Requires CLKS_PER_BIT≥8; elaboration error otherwise.
- Undefined: a single sample at mid-bit. No extra flops.

Test Plan:
Common configuration: CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1 (N=11), unless stated otherwise.
- TX 0xA5 accepted at cycle t:
  - tx_serial shows 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 16 cycles.
  - tx_done at t+177; tx_active high for exactly 176 cycles.
- tx_serial looped to rx_serial; 0x00, 0xFF, 0x3C sent back-to-back, with tx_start in each tx_done cycle:
  - Three rx_done pulses with matching rx_data; parity_error=frame_error=0.
  - tx_active low for exactly one cycle between frames.
- RX frame 0x5A with parity bit forced to 1 → rx_done, rx_data=0x5A, parity_error=1, frame_error=0. A following good 0x11 frame clears parity_error.
- Stop bit driven 0 on frame 0x42 → frame_error=1, rx_data=0x42. Then the line is held low for 20 bit times:
  - Exactly one further rx_done, with rx_data=0x00 and frame_error=1.
  - No further rx_done until the line goes high; the next 0x7E frame is received cleanly.
- Idle-line low glitch of 5 cycles → no rx_done and flags unchanged. With UART_RX_MAJORITY_EN, a 1-cycle inversion at mid data bit 3 of 0x5A still yields 0x5A.
- rst pulsed during TX data bit 3 → tx_serial=1 and tx_active=0 within the reset cycle, and no tx_done. After release, a new tx_start of 0xC3 transmits correctly.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART engine (one TX, one RX) with false-start
// rejection and break handling. Define UART_RX_MAJORITY_EN for 2-of-3 voting around each RX mid-bit sample.
module uart_core_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_error,
    output logic                 frame_error
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY_MODE != 0) ? 1'b1 : 1'b0;
    localparam logic             ODD_PARITY = (PARITY_MODE == 2) ? 1'b1 : 1'b0;

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_chk_cpb
        $error("uart_core_param: CLKS_PER_BIT must be an even number >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_core_param: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_par
        $error("uart_core_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_core_param: STOP_BITS must be 1 or 2");
    end
`ifdef UART_RX_MAJORITY_EN
    if (CLKS_PER_BIT < 8) begin : g_chk_major
        $error("uart_core_param: majority sampling needs CLKS_PER_BIT >= 8");
    end
`endif

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        return (^word) ^ ODD_PARITY;
    endfunction

    tx_state_t            tx_state_r;
    logic [CNT_W-1:0]     tx_cnt_r;
    logic [3:0]           tx_idx_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic                 tx_serial_r;
    logic                 tx_active_r;
    logic                 tx_done_r;

    rx_state_t            rx_state_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_bit_s;
    logic                 rx_armed_r;
    logic [CNT_W-1:0]     rx_cnt_r;
    logic [3:0]           rx_idx_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_r;
    logic                 rx_stop_err_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_done_r;
    logic                 parity_error_r;
    logic                 frame_error_r;

    // TX frame sequencer: state, baud counter, bit index and the registered serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= '0;
            tx_idx_r    <= 4'd0;
            tx_shift_r  <= '0;
            tx_par_r    <= 1'b0;
            tx_serial_r <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state_r  <= TX_START;
                        tx_cnt_r    <= '0;
                        tx_idx_r    <= 4'd0;
                        tx_shift_r  <= tx_data;
                        tx_par_r    <= parity_bit(tx_data);
                        tx_serial_r <= 1'b0;
                        tx_active_r <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r    <= '0;
                        tx_state_r  <= TX_DATA;
                        tx_serial_r <= tx_shift_r[0];
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_idx_r == DATA_LAST) begin
                            tx_idx_r <= 4'd0;
                            if (HAS_PARITY) begin
                                tx_state_r  <= TX_PARITY;
                                tx_serial_r <= tx_par_r;
                            end else begin
                                tx_state_r  <= TX_STOP;
                                tx_serial_r <= 1'b1;
                            end
                        end else begin
                            tx_idx_r    <= tx_idx_r + 4'd1;
                            tx_shift_r  <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                            tx_serial_r <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r    <= '0;
                        tx_state_r  <= TX_STOP;
                        tx_serial_r <= 1'b1;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_idx_r == STOP_LAST) begin
                            tx_idx_r    <= 4'd0;
                            tx_state_r  <= TX_IDLE;
                            tx_active_r <= 1'b0;
                            tx_done_r   <= 1'b1;
                        end else begin
                            tx_idx_r <= tx_idx_r + 4'd1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r  <= TX_IDLE;
                    tx_serial_r <= 1'b1;
                    tx_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser; resets low so the receiver must observe a real idle-high line to arm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
        end else begin
            rx_meta_r <= rx_serial;
            rx_sync_r <= rx_meta_r;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist_r;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two previous synchronised samples; the vote is taken one cycle after mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hist_r <= 2'b00;
        end else begin
            rx_hist_r <= {rx_hist_r[0], rx_sync_r};
        end
    end

    assign rx_bit_s = majority3(rx_hist_r[1], rx_hist_r[0], rx_sync_r);
`else
    assign rx_bit_s = rx_sync_r;
`endif

    // RX frame sequencer: arming, start re-check, mid-bit sampling and result/flag update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r     <= RX_IDLE;
            rx_armed_r     <= 1'b0;
            rx_cnt_r       <= '0;
            rx_idx_r       <= 4'd0;
            rx_shift_r     <= '0;
            rx_par_r       <= 1'b0;
            rx_stop_err_r  <= 1'b0;
            rx_data_r      <= '0;
            rx_done_r      <= 1'b0;
            parity_error_r <= 1'b0;
            frame_error_r  <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    if (!rx_armed_r) begin
                        rx_armed_r <= rx_sync_r;
                    end else if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r      <= '0;
                        rx_idx_r      <= 4'd0;
                        rx_stop_err_r <= 1'b0;
                        rx_state_r    <= rx_bit_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_bit_s, rx_shift_r[DATA_BITS-1:1]};
                        if (rx_idx_r == DATA_LAST) begin
                            rx_idx_r   <= 4'd0;
                            rx_state_r <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 4'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_par_r   <= rx_bit_s;
                        rx_state_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r <= '0;
                        if (rx_idx_r == STOP_LAST) begin
                            // Result is committed even on error; a break lands here as data 0 with frame_error
                            rx_data_r      <= rx_shift_r;
                            parity_error_r <= HAS_PARITY & (rx_par_r ^ parity_bit(rx_shift_r));
                            frame_error_r  <= rx_stop_err_r | ~rx_bit_s;
                            rx_done_r      <= 1'b1;
                            rx_idx_r       <= 4'd0;
                            rx_armed_r     <= 1'b0;
                            rx_state_r     <= RX_IDLE;
                        end else begin
                            rx_stop_err_r <= rx_stop_err_r | ~rx_bit_s;
                            rx_idx_r      <= rx_idx_r + 4'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_armed_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial    = tx_serial_r;
    assign tx_active    = tx_active_r;
    assign tx_done      = tx_done_r;
    assign rx_data      = rx_data_r;
    assign rx_done      = rx_done_r;
    assign parity_error = parity_error_r;
    assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed + randomized bench for uart_core_param (16 clk/bit, 8 data bits, even parity, 1 stop).
// Expected serial frames and receive results come from a bit-list model built from the frame rules.
module tb_uart_core_param;

    localparam int C = 16;
    localparam int D = 8;
    localparam int P = 1;
    localparam int S = 1;
    localparam int N = 1 + D + ((P != 0) ? 1 : 0) + S;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;
    logic       rx_line;
    logic       rx_drv;
    logic       loop_en;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int tx_done_cnt = 0;
    logic [9:0] rx_q[$];

    assign rx_line = loop_en ? tx_serial : rx_drv;

    uart_core_param #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (D),
        .PARITY_MODE (P),
        .STOP_BITS   (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_serial   (tx_serial),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .rx_serial   (rx_line),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .parity_error(parity_error),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Record every receive result and count transmit completions
    always @(negedge clk) begin
        if (!rst && rx_done) rx_q.push_back({parity_error, frame_error, rx_data});
        if (!rst && tx_done) tx_done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Line levels of one frame, index 0 = start bit: LSB-first data, even parity, stop.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic par_flip,
                                               input logic stop_val);
        logic [15:0] b;
        b    = 16'hFFFF;
        b[0] = 1'b0;
        for (int i = 0; i < D; i++) b[1+i] = d[i];
        b[1+D] = (^d) ^ par_flip;
        b[2+D] = stop_val;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        logic [15:0] b;
        b        = frame_bits(d, 1'b0, 1'b1);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        for (int k = 1; k <= N * C; k++) begin
            @(negedge clk);
            check("tx_frame", {tx_serial, tx_active, tx_done}, {b[(k-1)/C], 1'b1, 1'b0});
        end
        @(negedge clk);
        check("tx_end", {tx_serial, tx_active, tx_done}, 3'b101);
    endtask

    task automatic drive_rx(input logic [15:0] b, input int glitch_at);
        for (int c = 0; c < N * C; c++) begin
            rx_drv = b[c/C] ^ ((c == glitch_at) ? 1'b1 : 1'b0);
            tick();
        end
        rx_drv = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        logic [9:0] got;
        for (int i = 0; i < 4 * C && rx_q.size() == 0; i++) tick();
        check({tag, "_present"}, (rx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            check({tag, "_data"}, got[7:0], d);
            check({tag, "_perr"}, got[9], pe);
            check({tag, "_ferr"}, got[8], fe);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b2b[3];
        logic       flip;
        logic       stp;
        logic       seen;
        int         done_before;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        rx_drv   = 1'b1;
        loop_en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_serial", tx_serial, 1'b1);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_perr", parity_error, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();

        // Transmit: directed 0xA5 then random words
        send_tx(8'hA5);
        tick();
        for (int r = 0; r < 3; r++) begin
            d = 8'($urandom_range(0, 255));
            send_tx(d);
            tick();
        end

        // Loopback, back-to-back frames started in the tx_done cycle
        loop_en = 1'b1;
        repeat (C) tick();
        check("loop_quiet", rx_q.size(), 32'd0);
        b2b[0]   = 8'h00;
        b2b[1]   = 8'hFF;
        b2b[2]   = 8'h3C;
        tx_data  = b2b[0];
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            seen = 1'b0;
            for (int j = 0; j < N * C + 8 && !seen; j++) begin
                @(negedge clk);
                seen = tx_done;
            end
            check("b2b_done", seen, 1'b1);
            if (f < 2) begin
                check("b2b_gap_low", tx_active, 1'b0);
                tx_data  = b2b[f+1];
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                check("b2b_gap_one", {tx_active, tx_serial}, 2'b10);
            end
        end
        repeat (2 * C) tick();
        expect_rx("lb0", b2b[0], 1'b0, 1'b0);
        expect_rx("lb1", b2b[1], 1'b0, 1'b0);
        expect_rx("lb2", b2b[2], 1'b0, 1'b0);
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (C) tick();

        // Parity error, then a good frame clears it
        drive_rx(frame_bits(8'h5A, 1'b1, 1'b1), -1);
        expect_rx("par_bad", 8'h5A, 1'b1, 1'b0);
        repeat (C) tick();
        drive_rx(frame_bits(8'h11, 1'b0, 1'b1), -1);
        expect_rx("par_clr", 8'h11, 1'b0, 1'b0);
        repeat (C) tick();

        // Random receive frames with random parity and stop corruption
        for (int r = 0; r < 6; r++) begin
            d    = 8'($urandom_range(0, 255));
            flip = 1'($urandom_range(0, 1));
            stp  = 1'($urandom_range(0, 1));
            drive_rx(frame_bits(d, flip, stp), -1);
            expect_rx("rx_rand", d, flip, ~stp);
            repeat (C) tick();
        end

        // Framing error, then a break
        drive_rx(frame_bits(8'h42, 1'b0, 1'b0), -1);
        expect_rx("stop_bad", 8'h42, 1'b0, 1'b1);
        repeat (C) tick();
        rx_drv = 1'b0;
        repeat (20 * C) tick();
        check("break_one_done", rx_q.size(), 32'd1);
        expect_rx("break", 8'h00, 1'b0, 1'b1);
        rx_drv = 1'b1;
        repeat (2 * C) tick();
        check("break_no_more", rx_q.size(), 32'd0);
        drive_rx(frame_bits(8'h7E, 1'b0, 1'b1), -1);
        expect_rx("after_break", 8'h7E, 1'b0, 1'b0);
        repeat (C) tick();

        // Short low glitch on an idle line is a false start
        rx_drv = 1'b0;
        repeat (5) tick();
        rx_drv = 1'b1;
        repeat (3 * C) tick();
        check("glitch_no_done", rx_q.size(), 32'd0);
        check("glitch_flags", {parity_error, frame_error, rx_data}, {2'b00, 8'h7E});

`ifdef UART_RX_MAJORITY_EN
        drive_rx(frame_bits(8'h5A, 1'b0, 1'b1), 4 * C + C / 2);
        expect_rx("majority", 8'h5A, 1'b0, 1'b0);
        repeat (C) tick();
`endif

        // Reset in the middle of data bit 3 (value 0 for 0x96)
        done_before = tx_done_cnt;
        tx_data     = 8'h96;
        tx_start    = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (4 * C + 5) tick();
        check("pre_rst_bit3", {tx_serial, tx_active}, 2'b01);
        rst = 1'b1;
        #1;
        check("mid_rst_serial", tx_serial, 1'b1);
        check("mid_rst_active", tx_active, 1'b0);
        @(negedge clk);
        check("mid_rst_rx", {parity_error, frame_error, rx_data}, 10'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (N * C + 4) tick();
        check("rst_no_done", tx_done_cnt, done_before);
        check("rst_idle_active", tx_active, 1'b0);
        send_tx(8'hC3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
